// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb4_rr.sv
// gf180mcu_fd_sc_mcu9t5v0__arb4_rr
//   Four-requester round-robin arbiter with break-before-make sequencing.
//   One client at a time owns a shared wide-drive resource. Every change of
//   owner passes through one dead cycle with no grant asserted.
//
// Ports:
//   CLK     in   1  rising-edge clock
//   RN      in   1  asynchronous active-low reset
//   REQ     in   4  level request per client, held high while the client needs the resource
//   GNT     out  4  registered one-hot grant
//   GNT_ID  out  2  binary index of the current owner; holds its last value when GNT == 0
//   BUSY    out  1  high whenever the arbiter is not idle (GRANT or GAP)
//   TOUT    out  1  one-cycle pulse during the GAP that follows a forced release
//   VDD/VSS inout   power pins, present only when USE_POWER_PINS is defined
//
// Optional feature (macro GF180MCU_FD_SC_MCU9T5V0_ARB_TIMEOUT_EN):
//   Bounds each ownership to MAX_HOLD consecutive GRANT cycles using a CNT_W-bit
//   hold counter. Without the macro grants are unbounded and TOUT is tied 0.
`timescale 1ns/1ps

module gf180mcu_fd_sc_mcu9t5v0__arb4_rr #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
`ifdef USE_POWER_PINS
    inout  wire        VDD,
    inout  wire        VSS,
`endif
    input  logic       CLK,
    input  logic       RN,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] GNT_ID,
    output logic       BUSY,
    output logic       TOUT
);

    // Reject a hold limit the counter cannot represent.
    if (MAX_HOLD < 2 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_max_hold
        $error("MAX_HOLD must lie in 2..2**CNT_W-1");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0] state;
    logic [1:0] ptr;
    logic [2:0] win;        // {found, index}
    logic       force_rel;

    // Round-robin search starting at ptr_v. Scanning from the lowest priority
    // upwards lets the highest-priority hit overwrite earlier ones.
    function automatic logic [2:0] pick(input logic [1:0] ptr_v, input logic [3:0] req_v);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_v + 2'(k);
            if (req_v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign win  = pick(ptr, REQ);
    assign BUSY = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= ST_IDLE;
            ptr    <= 2'd0;
            GNT    <= 4'b0000;
            GNT_ID <= 2'd0;
        end else begin
            case (state)
                // GAP arbitrates exactly like IDLE; the pointer has already
                // moved past the previous owner, so it has lowest priority.
                ST_IDLE, ST_GAP: begin
                    if (win[2]) begin
                        state  <= ST_GRANT;
                        GNT    <= 4'b0001 << win[1:0];
                        GNT_ID <= win[1:0];
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!REQ[GNT_ID] || force_rel) begin
                        state <= ST_GAP;
                        GNT   <= 4'b0000;
                        ptr   <= GNT_ID + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB_TIMEOUT_EN
    // hold_cnt is 0 in the first GRANT cycle, so the owner's MAX_HOLD-th
    // cycle is the one where it reads MAX_HOLD-1.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;

    // A request dropping on the limit edge is a normal release, not a timeout.
    assign force_rel = (state == ST_GRANT) && REQ[GNT_ID] && (hold_cnt == HOLD_LAST);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            hold_cnt <= '0;
            TOUT     <= 1'b0;
        end else begin
            TOUT <= force_rel;
            if (state == ST_GRANT) hold_cnt <= hold_cnt + 1'b1;
            else                   hold_cnt <= '0;
        end
    end
`else
    assign force_rel = 1'b0;
    assign TOUT      = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__arb4_rr.sv
// Testbench for gf180mcu_fd_sc_mcu9t5v0__arb4_rr: directed stimulus with literal
// expectations plus an owner/dead-cycle model checked on every clock and reset edge.
`timescale 1ns/1ps

module tb_gf180mcu_fd_sc_mcu9t5v0__arb4_rr;

    localparam int HOLD = 4;
`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RN;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       BUSY;
    logic       TOUT;
`ifdef USE_POWER_PINS
    wire vdd = 1'b1;
    wire vss = 1'b0;
`endif

    gf180mcu_fd_sc_mcu9t5v0__arb4_rr #(.MAX_HOLD(HOLD), .CNT_W(4)) dut (
`ifdef USE_POWER_PINS
        .VDD(vdd),
        .VSS(vss),
`endif
        .CLK(CLK),
        .RN(RN),
        .REQ(REQ),
        .GNT(GNT),
        .GNT_ID(GNT_ID),
        .BUSY(BUSY),
        .TOUT(TOUT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the resource, whether we are in the dead cycle, and the
    // round-robin start index. Ownership is described by index, not by state code.
    int m_owner;   // -1 when nobody owns
    int m_ptr;
    int m_held;    // GRANT cycles completed including the current one
    int m_last;
    bit m_gap;
    bit m_tout;

    always @(posedge CLK or negedge RN) begin
        if (!RN) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_last = 0; m_gap = 0; m_tout = 0;
        end else begin
            m_tout = 0;
            if (m_owner >= 0) begin
                if (!REQ[m_owner]) begin
                    m_ptr = (m_owner + 1) % 4; m_owner = -1; m_gap = 1;
                end else if (TO_EN && m_held == HOLD) begin
                    m_ptr = (m_owner + 1) % 4; m_owner = -1; m_gap = 1; m_tout = 1;
                end else begin
                    m_held++;
                end
            end else begin
                m_gap = 0;
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && REQ[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        m_last  = m_owner;
                        m_held  = 1;
                    end
                end
            end
        end
    end

    logic [3:0] prev_gnt = 4'b0000;

    always @(posedge CLK or negedge RN) begin
        #1;
        chk("model_gnt",    GNT,    (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
        chk("model_gnt_id", GNT_ID, m_last);
        chk("model_busy",   BUSY,   (m_owner >= 0) || m_gap);
        chk("model_tout",   TOUT,   m_tout);
        chk("onehot",       ($countones(GNT) <= 1), 1);
        if (prev_gnt != 4'b0000 && GNT != 4'b0000)
            chk("break_before_make", GNT, prev_gnt);
        prev_gnt = GNT;
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        RN  = 1'b0;
        REQ = 4'b1111;
        tick(); tick();
        chk("rst_gnt",    GNT, 0);
        chk("rst_gnt_id", GNT_ID, 0);
        chk("rst_busy",   BUSY, 0);
        chk("rst_tout",   TOUT, 0);

        // Rotating priority, each owner holds three cycles then drops.
        RN = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rr_gnt", GNT, seq[i]);
            tick(); tick();
            REQ = 4'b1111 & ~seq[i];
            tick();
            chk("rr_gap_gnt",  GNT, 0);
            chk("rr_gap_busy", BUSY, 1);
            REQ = 4'b1111;
            tick();
        end

        // Asynchronous reset in the middle of a grant.
        REQ = 4'b0100;
        tick(); tick();
        chk("pre_rst_gnt", GNT, 4'b0100);
        #2 RN = 1'b0;
        #1;
        chk("async_rst_gnt",  GNT, 0);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_id",   GNT_ID, 0);
        tick();
        RN  = 1'b1;
        REQ = 4'b0100;
        tick();
        chk("post_rst_gnt", GNT, 4'b0100);
        chk("post_rst_id",  GNT_ID, 2);

        // Single requester regranted after one dead cycle.
        REQ = 4'b1000;
        tick(); tick();
        chk("single_gnt", GNT, 4'b1000);
        tick();
        REQ = 4'b0000;
        tick();
        chk("single_gap_gnt",  GNT, 0);
        chk("single_gap_busy", BUSY, 1);
        REQ = 4'b1000;
        tick();
        chk("single_regrant", GNT, 4'b1000);
        chk("single_busy",    BUSY, 1);

        // Previous owner has lowest priority after its release.
        REQ = 4'b0010;
        tick(); tick();
        chk("lp_owner1", GNT, 4'b0010);
        REQ = 4'b0001;
        tick();
        chk("lp_gap", GNT, 0);
        REQ = 4'b0011;
        tick();
        chk("lp_ptr2_pick0", GNT, 4'b0001);
        REQ = 4'b0110;
        tick(); tick();
        chk("lp_owner1b", GNT, 4'b0010);
        REQ = 4'b1001;
        tick(); tick();
        chk("lp_pick3_over0", GNT, 4'b1000);
        chk("lp_id3", GNT_ID, 3);

        // Return to idle, then long holds.
        REQ = 4'b0000;
        tick(); tick();
        chk("idle_busy", BUSY, 0);
        REQ = 4'b0011;
        tick();
`ifdef GF180MCU_FD_SC_MCU9T5V0_ARB_TIMEOUT_EN
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < HOLD; c++) begin
                chk("to_hold_gnt",  GNT, 32'(1 << (r % 2)));
                chk("to_hold_tout", TOUT, 0);
                tick();
            end
            chk("to_gap_gnt",  GNT, 0);
            chk("to_gap_tout", TOUT, 1);
            tick();
        end
        for (int c = 0; c < HOLD - 1; c++) begin
            chk("edge_hold_gnt", GNT, 4'b0001);
            tick();
        end
        chk("edge_last_gnt", GNT, 4'b0001);
        REQ = 4'b0010;
        tick();
        chk("edge_gap_gnt",  GNT, 0);
        chk("edge_gap_tout", TOUT, 0);
        tick();
        chk("edge_next_gnt", GNT, 4'b0010);
`else
        REQ = 4'b0001;
        for (int c = 0; c < 100; c++) begin
            chk("unbounded_gnt",  GNT, 4'b0001);
            chk("unbounded_tout", TOUT, 0);
            tick();
        end
`endif
        REQ = 4'b0000;
        tick(); tick(); tick();
        chk("end_busy", BUSY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
